// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared types and constants for the elastic pipeline stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_t;

    localparam logic [1:0] PIPE_OCC_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_OCC_ONE   = 2'd1;
    localparam logic [1:0] PIPE_OCC_TWO   = 2'd2;

    localparam int PIPE_STALL_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module  : pipe_skid_reg
// Brief   : Elastic pipeline register with one-entry skid buffer, registered
//           in_ready and synchronous flush to a bubble value.
//           Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
`ifdef PIPE_STALL_CNT_EN
    output logic [PIPE_STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [1:0]                  occupancy
);

    pipe_state_t      r_state;
    pipe_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    assign out_valid  = (r_state != PIPE_EMPTY);
    assign out_data   = r_main;
    assign in_ready   = r_in_ready;
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = PIPE_EMPTY;
        end else begin
            case (r_state)
                PIPE_EMPTY: if (w_in_fire) w_state_nxt = PIPE_ONE;
                PIPE_ONE: begin
                    if (w_in_fire && !w_out_fire)
                        w_state_nxt = PIPE_TWO;
                    else if (!w_in_fire && w_out_fire)
                        w_state_nxt = PIPE_EMPTY;
                end
                PIPE_TWO:   if (w_out_fire) w_state_nxt = PIPE_ONE;
                default:    w_state_nxt = PIPE_EMPTY;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            PIPE_ONE: occupancy = PIPE_OCC_ONE;
            PIPE_TWO: occupancy = PIPE_OCC_TWO;
            default:  occupancy = PIPE_OCC_EMPTY;
        endcase
    end

    // in_ready is precomputed from the next state so no ready path crosses the stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PIPE_EMPTY;
            r_main     <= RST_VAL;
            r_skid     <= RST_VAL;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != PIPE_TWO);
            if (flush) begin
                r_main <= BUBBLE_VAL;
            end else begin
                case (r_state)
                    PIPE_EMPTY: if (w_in_fire) r_main <= in_data;
                    PIPE_ONE: begin
                        if (w_in_fire) begin
                            if (w_out_fire) r_main <= in_data;
                            else            r_skid <= in_data;
                        end
                    end
                    PIPE_TWO:   if (w_out_fire) r_main <= r_skid;
                    default:    r_main <= r_main;
                endcase
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [PIPE_STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline register: generic replacement for the fixed-field stall/flush stage registers between IF/ID/EX/MEM.
- Carries an arbitrary WIDTH payload with valid/ready handshake and a one-entry skid buffer, so in_ready is a pure flop output. Upstream and downstream stalls decouple with no combinational ready path.
- Provides synchronous flush with a configurable bubble value, replacing per-stage hand-written flush/stall branches.

Parameters:
WIDTH, 16, payload width in bits (>=1)
RST_VAL, 0, value driven on out_data after reset (WIDTH bits)
BUBBLE_VAL, 0, value loaded into out_data on flush (encodes a NOP/bubble)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; registered
in_data  in  WIDTH  upstream payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  downstream payload; stable while out_valid & !out_ready
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset is asynchronous and active-high; the clock is clk. While rst is high: state EMPTY, out_valid=0, out_data=RST_VAL, in_ready=1, occupancy=0, skid register=RST_VAL.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main reg valid, occ 1), TWO (main + skid valid, occ 2).
- out_valid = (state != EMPTY). out_data = main reg. in_ready is registered, equal to (next_state != TWO).
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE, in_fire & out_fire -> ONE, main <= in_data.
- ONE, in_fire & !out_fire -> TWO, skid <= in_data.
- ONE, !in_fire & out_fire -> EMPTY.
- ONE, neither fire -> hold.
- TWO: in_ready=0, so no in_fire. out_fire -> ONE, main <= skid. Otherwise hold.
- Latency: a word accepted in cycle N is presented (out_valid=1) in cycle N+1. Sustained throughput is 1 word/cycle when out_ready stays high.
- Ordering is strict FIFO; no word is dropped or duplicated except on flush.
- Flush has priority over all handshakes. Next state is EMPTY, out_data <= BUBBLE_VAL, in_ready <= 1, occupancy <= 0.
- A word presented with in_fire in the flush cycle is discarded. An out_fire in the flush cycle still counts as consumed.
- Reset asserted mid-transfer overrides everything immediately, with no clock required.
- Payload held in main/skid is never modified while valid and not consumed.
- occupancy width is fixed at 2 bits regardless of WIDTH.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0]: increments each cycle with out_valid & !out_ready & !flush, and saturates at 16'hFFFF.
  - Cleared by rst and by flush.
- Undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (PIPE_EMPTY=2'd0, PIPE_ONE=2'd1, PIPE_TWO=2'd2);
  - occupancy constants;
  - stall counter width constant PIPE_STALL_CNT_W=16.
- No sub-module inside this block. A later pipe_chain wrapper instantiates DEPTH copies of pipe_skid_reg.

Test Plan:
1. Reset, then stream 0x0001..0x0008 with in_valid=1 and out_ready=1 -> out_data 0x0001..0x0008 on consecutive cycles starting one cycle after the first accept; occupancy stays 1.
2. Backpressure: accept 0x00A1, then 0x00A2 with out_ready=0 -> occupancy=2, in_ready=0 next cycle, out_data held at 0x00A1. Raising out_ready yields 0x00A1 then 0x00A2, with in_ready returning to 1 after the first drain.
3. Flush in state TWO (0x1111, 0x2222 held) with in_valid=1, in_data=0x3333 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1. 0x3333 is never output.
4. Async reset pulsed mid-stream between clock edges -> out_valid=0, out_data=RST_VAL, in_ready=1 immediately, before the next edge.
5. Random in_valid/out_ready (50%/50%, 10k cycles, WIDTH=37) -> scoreboard: strict order, no loss or duplication, out_data stable whenever out_valid & !out_ready.
6. With PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. A flush then clears it to 0.
